// File: rtl/dcache_arb_pkg.sv
// Shared types and sizes for the data-cache request arbiter.
package dcache_arb_pkg;

  localparam int unsigned NR_REQ    = 3;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned ID_W      = 3;
  localparam int unsigned POOL_SIZE = 1 << ID_W;
  localparam int unsigned SRC_W     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  // Output slot: everything the HPDcache sees, held stable until accepted.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [ID_W-1:0]   id;
    logic [SRC_W-1:0]  src;
  } slot_t;

  // One entry per transaction ID: allocated flag and the requester that owns it.
  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] src;
  } id_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after the pointer wins,
// pointer moves to winner+1 when a grant is taken and updates are enabled.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] elig_i,
  input  logic         upd_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Winner search in two passes: indices at/after the pointer, then wrap to the bottom.
  always_comb begin
    int   win_hi;
    int   win_lo;
    int   win;
    logic found_hi;
    logic found_lo;
    win_hi   = 0;
    win_lo   = 0;
    win      = 0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    gnt_o    = '0;
    ptr_d    = ptr_q;
    for (int i = 0; i < int'(N); i++) begin
      if (!found_hi && elig_i[i] && (i >= int'(ptr_q))) begin
        found_hi = 1'b1;
        win_hi   = i;
      end
      if (!found_lo && elig_i[i]) begin
        found_lo = 1'b1;
        win_lo   = i;
      end
    end
    win = found_hi ? win_hi : win_lo;
    for (int i = 0; i < int'(N); i++) begin
      gnt_o[i] = found_lo && (win == i);
    end
    if (upd_i && found_lo) begin
      ptr_d = (win + 1 >= int'(N)) ? '0 : PW'(win + 1);
    end
  end

  // Pointer register; index 0 has priority after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares the HPDcache request port between the core requesters, allocates a
// transaction ID per accepted request and routes responses back by ID.
module dcache_req_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NrReq          = NR_REQ,
  parameter int unsigned AddrWidth      = ADDR_W,
  parameter int unsigned DataWidth      = DATA_W,
  parameter int unsigned IdWidth        = ID_W,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NrReq-1:0]             req_valid_i,
  output logic [NrReq-1:0]             req_ready_o,
  input  logic [NrReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NrReq-1:0]             req_we_i,
  input  logic [NrReq*DataWidth/8-1:0] req_be_i,
  input  logic [NrReq*DataWidth-1:0]   req_wdata_i,
  output logic                         cache_req_valid_o,
  input  logic                         cache_req_ready_i,
  output logic [AddrWidth-1:0]         cache_req_addr_o,
  output logic                         cache_req_we_o,
  output logic [DataWidth/8-1:0]       cache_req_be_o,
  output logic [DataWidth-1:0]         cache_req_wdata_o,
  output logic [IdWidth-1:0]           cache_req_id_o,
  input  logic                         cache_rsp_valid_i,
  input  logic [IdWidth-1:0]           cache_rsp_id_i,
  input  logic [DataWidth-1:0]         cache_rsp_rdata_i,
  input  logic                         cache_rsp_error_i,
  output logic [NrReq-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]         rsp_rdata_o,
  output logic                         rsp_error_o,
  input  logic                         flush_i,
  output logic                         idle_o,
  output logic                         id_err_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned Pool    = 1 << IdWidth;
  localparam int unsigned SrcW    = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

  slot_t            slot_q, slot_d;
  logic             slot_vld_q, slot_vld_d;
  id_entry_t        id_tbl_q [Pool];
  id_entry_t        id_tbl_d [Pool];
  logic [CntW-1:0]  outst_q [NrReq];
  logic [CntW-1:0]  outst_d [NrReq];
  logic             id_err_q, id_err_d;

  logic             slot_free;
  logic [Pool-1:0]  id_bitmap;
  logic             any_free;
  logic [IdWidth-1:0] free_id;
  logic [NrReq-1:0] elig;
  logic [NrReq-1:0] gnt;
  logic [SrcW-1:0]  win_src;
  id_entry_t        rsp_entry;
  logic             rsp_hit;

  rr_arbiter #(.N(NrReq)) u_rr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .elig_i (elig),
    .upd_i  (1'b1),
    .gnt_o  (gnt)
  );

  // Free-ID search (lowest free wins) and requester eligibility.
  always_comb begin
    id_bitmap = '0;
    free_id   = '0;
    for (int i = 0; i < int'(Pool); i++) begin
      id_bitmap[i] = id_tbl_q[i].valid;
    end
    for (int i = int'(Pool) - 1; i >= 0; i--) begin
      if (!id_tbl_q[i].valid) free_id = IdWidth'(i);
    end
    any_free  = ~&id_bitmap;
    slot_free = ~slot_vld_q | cache_req_ready_i;
    for (int i = 0; i < NrReq; i++) begin
      elig[i] = req_valid_i[i] && (outst_q[i] < CntW'(MaxOutstanding)) &&
                any_free && slot_free && !flush_i;
    end
  end

  // Response lookup, slot/ID-table/counter next state.
  always_comb begin
    rsp_entry  = id_tbl_q[cache_rsp_id_i];
    rsp_hit    = cache_rsp_valid_i && rsp_entry.valid;
    id_err_d   = id_err_q | (cache_rsp_valid_i & ~rsp_entry.valid);

    win_src = '0;
    for (int i = 0; i < NrReq; i++) begin
      if (gnt[i]) win_src = SrcW'(i);
    end

    slot_d     = slot_q;
    slot_vld_d = slot_vld_q & ~cache_req_ready_i;
    if (|gnt) begin
      slot_vld_d = 1'b1;
      slot_d.id  = free_id;
      slot_d.src = win_src;
      for (int i = 0; i < NrReq; i++) begin
        if (gnt[i]) begin
          slot_d.addr  = req_addr_i[i*AddrWidth +: AddrWidth];
          slot_d.we    = req_we_i[i];
          slot_d.be    = req_be_i[i*BeWidth +: BeWidth];
          slot_d.wdata = req_wdata_i[i*DataWidth +: DataWidth];
        end
      end
    end

    // The freed ID is never free_id: free_id was unallocated, the responding one was not.
    for (int i = 0; i < int'(Pool); i++) begin
      id_tbl_d[i] = id_tbl_q[i];
    end
    if (rsp_hit) id_tbl_d[cache_rsp_id_i].valid = 1'b0;
    if (|gnt) begin
      id_tbl_d[free_id].valid = 1'b1;
      id_tbl_d[free_id].src   = win_src;
    end

    for (int i = 0; i < NrReq; i++) begin
      outst_d[i]     = outst_q[i];
      rsp_valid_o[i] = rsp_hit && (rsp_entry.src == SrcW'(i));
      if (gnt[i] && !rsp_valid_o[i]) begin
        outst_d[i] = outst_q[i] + CntW'(1);
      end else if (!gnt[i] && rsp_valid_o[i]) begin
        outst_d[i] = outst_q[i] - CntW'(1);
      end
    end
  end

  // State registers; reset discards every in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      id_err_q   <= 1'b0;
      for (int i = 0; i < int'(Pool); i++) id_tbl_q[i] <= '0;
      for (int i = 0; i < NrReq; i++) outst_q[i] <= '0;
    end else begin
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
      id_err_q   <= id_err_d;
      for (int i = 0; i < int'(Pool); i++) id_tbl_q[i] <= id_tbl_d[i];
      for (int i = 0; i < NrReq; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign req_ready_o       = gnt;
  assign cache_req_valid_o = slot_vld_q;
  assign cache_req_addr_o  = slot_q.addr;
  assign cache_req_we_o    = slot_q.we;
  assign cache_req_be_o    = slot_q.be;
  assign cache_req_wdata_o = slot_q.wdata;
  assign cache_req_id_o    = slot_q.id;
  assign rsp_rdata_o       = rsp_hit ? cache_rsp_rdata_i : '0;
  assign rsp_error_o       = rsp_hit & cache_rsp_error_i;
  assign idle_o            = ~slot_vld_q & ~|id_bitmap;
  assign id_err_o          = id_err_q;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter (3 requesters, 64-bit, 8 IDs, 4 outstanding).
module tb_dcache_req_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [191:0] req_addr;
  logic [2:0]   req_we;
  logic [23:0]  req_be;
  logic [191:0] req_wdata;
  logic         c_valid;
  logic         c_ready;
  logic [63:0]  c_addr;
  logic         c_we;
  logic [7:0]   c_be;
  logic [63:0]  c_wdata;
  logic [2:0]   c_id;
  logic         r_valid_in;
  logic [2:0]   r_id;
  logic [63:0]  r_rdata_in;
  logic         r_err_in;
  logic [2:0]   rsp_valid;
  logic [63:0]  rsp_rdata;
  logic         rsp_error;
  logic         flush;
  logic         idle;
  logic         id_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dcache_req_arbiter dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_we_i          (req_we),
    .req_be_i          (req_be),
    .req_wdata_i       (req_wdata),
    .cache_req_valid_o (c_valid),
    .cache_req_ready_i (c_ready),
    .cache_req_addr_o  (c_addr),
    .cache_req_we_o    (c_we),
    .cache_req_be_o    (c_be),
    .cache_req_wdata_o (c_wdata),
    .cache_req_id_o    (c_id),
    .cache_rsp_valid_i (r_valid_in),
    .cache_rsp_id_i    (r_id),
    .cache_rsp_rdata_i (r_rdata_in),
    .cache_rsp_error_i (r_err_in),
    .rsp_valid_o       (rsp_valid),
    .rsp_rdata_o       (rsp_rdata),
    .rsp_error_o       (rsp_error),
    .flush_i           (flush),
    .idle_o            (idle),
    .id_err_o          (id_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic we,
                         input logic [7:0] be, input logic [63:0] wd);
    req_addr[i*64 +: 64]  = a;
    req_we[i]             = we;
    req_be[i*8 +: 8]      = be;
    req_wdata[i*64 +: 64] = wd;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_we     = '0;
    req_be     = '0;
    req_wdata  = '0;
    c_ready    = 1'b0;
    r_valid_in = 1'b0;
    r_id       = '0;
    r_rdata_in = '0;
    r_err_in   = 1'b0;
    flush      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_gnt [8];
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    // Reset state
    do_reset();
    #1;
    chk("rst_cvalid", c_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_iderr", id_err, 0);
    chk("rst_caddr", c_addr, 0);

    // Single request from requester 1, then its response
    set_req(1, 64'h8000_0040, 1'b0, 8'hFF, 64'h0);
    req_valid = 3'b010;
    c_ready   = 1'b1;
    #1;
    chk("s1_gnt", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
    chk("s1_cvalid", c_valid, 1);
    chk("s1_cid", c_id, 0);
    chk("s1_caddr", c_addr, 64'h8000_0040);
    chk("s1_idle_busy", idle, 0);
    tick();
    r_valid_in = 1'b1;
    r_id       = 3'd0;
    r_rdata_in = 64'hDEAD;
    #1;
    chk("s1_rspv", rsp_valid, 3'b010);
    chk("s1_rdata", rsp_rdata, 64'hDEAD);
    tick();
    r_valid_in = 1'b0;
    #1;
    chk("s1_idle", idle, 1);

    // All three requesters: round-robin until the ID pool is exhausted
    do_reset();
    c_ready   = 1'b1;
    req_valid = 3'b111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("s2_gnt%0d", k), req_ready, exp_gnt[k]);
      if (k > 0) chk($sformatf("s2_id%0d", k - 1), c_id, k - 1);
      tick();
    end
    #1;
    chk("s2_full_gnt", req_ready, 0);
    chk("s2_id7", c_id, 7);
    tick();
    #1;
    chk("s2_full_gnt2", req_ready, 0);
    chk("s2_slot_empty", c_valid, 0);
    r_valid_in = 1'b1;
    r_id       = 3'd3;
    r_rdata_in = 64'h1234;
    #1;
    chk("s2_rsp3", rsp_valid, 3'b001);
    chk("s2_nosame", req_ready, 0);
    tick();
    r_valid_in = 1'b0;
    #1;
    chk("s2_regnt", req_ready, 3'b100);
    tick();
    req_valid = '0;
    #1;
    chk("s2_reid", c_id, 3);

    // Requester 0 alone hits its outstanding limit
    do_reset();
    c_ready   = 1'b1;
    req_valid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("s3_gnt%0d", k), req_ready, 3'b001);
      tick();
    end
    #1;
    chk("s3_stall", req_ready, 0);
    tick();
    #1;
    chk("s3_stall2", req_ready, 0);
    r_valid_in = 1'b1;
    r_id       = 3'd2;
    #1;
    chk("s3_rsp2", rsp_valid, 3'b001);
    chk("s3_stall3", req_ready, 0);
    tick();
    r_valid_in = 1'b0;
    #1;
    chk("s3_regnt", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    chk("s3_reid", c_id, 2);

    // Backpressure from the cache holds the slot stable
    do_reset();
    c_ready = 1'b0;
    set_req(0, 64'h1234_0000, 1'b1, 8'hF0, 64'hCAFE);
    req_valid = 3'b001;
    #1;
    chk("s4_gnt", req_ready, 3'b001);
    tick();
    set_req(0, 64'h5555_0000, 1'b0, 8'h0F, 64'hBEEF);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("s4_v%0d", c), c_valid, 1);
      chk($sformatf("s4_addr%0d", c), c_addr, 64'h1234_0000);
      chk($sformatf("s4_wd%0d", c), {c_we, c_be, c_wdata[54:0]}, {1'b1, 8'hF0, 55'hCAFE});
      chk($sformatf("s4_nogt%0d", c), req_ready, 0);
      tick();
    end
    c_ready = 1'b1;
    #1;
    chk("s4_refill_gnt", req_ready, 3'b001);
    chk("s4_hold_addr", c_addr, 64'h1234_0000);
    tick();
    req_valid = '0;
    #1;
    chk("s4_new_addr", c_addr, 64'h5555_0000);
    chk("s4_new_id", c_id, 1);
    chk("s4_new_be", c_be, 8'h0F);

    // Response with an unallocated ID
    do_reset();
    r_valid_in = 1'b1;
    r_id       = 3'd5;
    #1;
    chk("s5_rspv", rsp_valid, 0);
    tick();
    r_valid_in = 1'b0;
    #1;
    chk("s5_iderr", id_err, 1);
    tick();
    tick();
    #1;
    chk("s5_sticky", id_err, 1);
    do_reset();
    #1;
    chk("s5_cleared", id_err, 0);

    // Flush with two IDs outstanding
    do_reset();
    c_ready   = 1'b1;
    req_valid = 3'b011;
    #1;
    chk("s6_gnt0", req_ready, 3'b001);
    tick();
    #1;
    chk("s6_gnt1", req_ready, 3'b010);
    tick();
    flush = 1'b1;
    #1;
    chk("s6_flush_gnt", req_ready, 0);
    chk("s6_slot_kept", c_valid, 1);
    chk("s6_slot_id", c_id, 1);
    tick();
    #1;
    chk("s6_busy", idle, 0);
    r_valid_in = 1'b1;
    r_id       = 3'd0;
    #1;
    chk("s6_rsp0", rsp_valid, 3'b001);
    tick();
    r_id = 3'd1;
    #1;
    chk("s6_busy2", idle, 0);
    chk("s6_rsp1", rsp_valid, 3'b010);
    tick();
    r_valid_in = 1'b0;
    #1;
    chk("s6_idle", idle, 1);
    chk("s6_flush_gnt2", req_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Shares the single HPDcache request port between NrReq core requesters: load unit, store unit and PTW by default.
- Arbitration is round-robin; the block allocates a cache transaction ID to each accepted request from a free pool of 2^IdWidth IDs.
- Responses are routed back to the originating requester by ID lookup.
- Sits between the load/store/PTW units and the HPDcache core request interface.

Parameters:
- NrReq, 3, number of requesters; index 0 has highest priority after reset.
- AddrWidth, 64, request address width.
- DataWidth, 64, data width; byte-enable width is DataWidth/8.
- IdWidth, 3, cache transaction ID width (DcacheIdWidth); pool size is 2^IdWidth.
- MaxOutstanding, 4, per-requester limit on in-flight transactions (1..2^IdWidth).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NrReq  request valid per requester
- req_ready_o  out  NrReq  request accepted this cycle (one-hot or zero)
- req_addr_i  in  NrReq*AddrWidth  packed addresses
- req_we_i  in  NrReq  write enable
- req_be_i  in  NrReq*DataWidth/8  byte enables
- req_wdata_i  in  NrReq*DataWidth  write data
- cache_req_valid_o  out  1  request to HPDcache
- cache_req_ready_i  in  1  HPDcache accepts
- cache_req_addr_o  out  AddrWidth
- cache_req_we_o  out  1
- cache_req_be_o  out  DataWidth/8
- cache_req_wdata_o  out  DataWidth
- cache_req_id_o  out  IdWidth  allocated transaction ID
- cache_rsp_valid_i  in  1  response valid (no backpressure)
- cache_rsp_id_i  in  IdWidth
- cache_rsp_rdata_i  in  DataWidth
- cache_rsp_error_i  in  1
- rsp_valid_o  out  NrReq  one-hot routed response
- rsp_rdata_o  out  DataWidth  shared response data
- rsp_error_o  out  1  shared response error
- flush_i  in  1  stop granting new requests
- idle_o  out  1  no IDs allocated and output slot empty
- id_err_o  out  1  sticky: response with unallocated ID

Behaviour:
- Reset (rst_i high at the clock edge) clears the following:
  - output slot valid
  - ID-valid bitmap
  - per-requester outstanding counters
  - id_err_o
  - round-robin pointer, set to 0
- After reset all outputs are 0 except idle_o=1. Reset mid-transaction discards all in-flight state; later responses for old IDs set id_err_o.
- Output slot: one register holding {addr, we, be, wdata, id, src}. cache_req_* is driven only from this register, so valid and payload stay stable until cache_req_ready_i.
- Slot is free when it is empty or is being accepted this cycle (valid & ready).
- Requester i is eligible when all of the following hold:
  - req_valid_i[i]=1
  - outstanding[i] < MaxOutstanding
  - at least one ID is free
  - slot is free
  - flush_i=0
- Round-robin: the winner is the first eligible index at or after the pointer, wrapping at NrReq. On a grant the pointer becomes winner+1 mod NrReq. With no grant the pointer holds.
- Grant is combinational: req_ready_o[winner]=1 in the same cycle.
- At the clock edge on a grant:
  - payload captured into the slot
  - lowest-numbered free ID allocated; its src is recorded in the ID table
  - outstanding[winner] incremented
  - cache_req_valid_o=1 from the next cycle
- Latency is 1 cycle from req handshake to cache_req_valid_o. Back-to-back throughput is 1 per cycle while cache_req_ready_i=1.
- Response handling when cache_rsp_valid_i=1 and the ID is allocated:
  - rsp_valid_o[src]=1 combinationally, with rdata and error forwarded
  - at the edge, the ID is freed and outstanding[src] decremented
  - a freed ID is allocatable from the next cycle, not the same cycle
- Response with an unallocated ID: rsp_valid_o stays 0, no state change, id_err_o set until reset.
- Same-cycle grant and response for the same requester: the counter's net change is 0.
- All IDs allocated: no grants; req_ready_o=0 for all requesters.
- flush_i does not cancel the output slot or in-flight IDs.
- idle_o = ~slot_valid & (ID bitmap == 0).

Decomposition:
- dcache_arb_pkg holds:
  - the slot struct type
  - the ID-table entry type {valid, src[$clog2(NrReq)]}
  - a localparam for pool size
- One sub-module: rr_arbiter, a parameterised round-robin arbiter with an eligibility vector, pointer update enable and one-hot grant.
- Free-ID selection is a leading-zero find inside the top level.

Test Plan:
- Reset, then requester 1 issues addr 0x8000_0040 with cache_req_ready_i=1:
  - req_ready_o=3'b010 in the same cycle
  - next cycle cache_req_valid_o=1, id=0, addr 0x8000_0040
  - response id 0 with rdata 0xDEAD gives rsp_valid_o=3'b010, rdata 0xDEAD
- All three requesters valid continuously, no responses:
  - grants go 0,1,2,0,1,2,0,1
  - IDs 0..7 are allocated
  - then req_ready_o=0 until a response frees an ID
- Requester 0 alone, MaxOutstanding=4:
  - 4 grants, then stall
  - a response for ID 2 makes the next grant occur the following cycle with id 2
- cache_req_ready_i=0 for 5 cycles with the slot full:
  - cache_req_* stays stable
  - no further req_ready_o
  - the slot refills on the cycle ready returns
- Response with an unallocated ID 5:
  - rsp_valid_o=0, id_err_o=1 and it stays 1
  - rst_i clears it
- flush_i=1 with 2 IDs outstanding:
  - no grants
  - idle_o=0 until both responses arrive
  - idle_o=1 the cycle after the last response
